sprite_rom_arbiter: RTL and testbench

- Shares one single-port image ROM (the shared sprite/level ROM feeding the picture blobs) among NUM_REQ pixel-fetch requesters.
- Round-robin grant, at most one ROM read issued per clock.
- Tracks in-flight reads through a fixed-latency pipeline and returns each data word tagged with its requester ID.
- Sits between the picture/sprite blobs and the ROM IP in the pixel clock domain.

---
 rtl/sprite_rom_arbiter.sv | 109 ++++++++++
 tb/tb_sprite_rom_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_rom_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sprite_rom_arbiter: round-robin sharing of one fixed-latency image ROM     |
// | among NUM_REQ pixel fetchers, responses tagged with requester id. Rev 1.0  |
// +----------------------------------------------------------------------------+
module sprite_rom_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int ROM_LATENCY = 2
) (
  input  logic                       pixel_clk_in,
  input  logic                       rst_n_in,
  input  logic [NUM_REQ-1:0]         req_valid_in,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr_in,
  output logic [NUM_REQ-1:0]         req_ready_out,
  output logic [ADDR_W-1:0]          rom_addr_out,
  output logic                       rom_en_out,
  input  logic [DATA_W-1:0]          rom_data_in,
  output logic                       rsp_valid_out,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id_out,
  output logic [DATA_W-1:0]          rsp_data_out
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0]   r_ptr;
  logic              r_rom_en;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [ID_W-1:0]   r_issue_id;
  logic [ROM_LATENCY-1:0] r_pipe_vld;
  logic [ID_W-1:0]   r_pipe_id [ROM_LATENCY];
  logic              r_rsp_valid;
  logic [ID_W-1:0]   r_rsp_id;
  logic [DATA_W-1:0] r_rsp_data;

  logic              w_found;
  logic [ID_W-1:0]   w_winner;
  logic [ADDR_W-1:0] w_addr [NUM_REQ];

  // Modulo-NUM_REQ add without '%', valid for non-power-of-2 requester counts.
  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return ID_W'(sum);
  endfunction

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_addr
    assign w_addr[i] = req_addr_in[i*ADDR_W +: ADDR_W];
  end

  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && req_valid_in[rr_index(r_ptr, k)]) begin
        w_found  = 1'b1;
        w_winner = rr_index(r_ptr, k);
      end
    end
  end

  always_comb begin
    req_ready_out = '0;
    if (w_found) req_ready_out[w_winner] = 1'b1;
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_ptr       <= '0;
      r_rom_en    <= 1'b0;
      r_rom_addr  <= '0;
      r_issue_id  <= '0;
      r_pipe_vld  <= '0;
      for (int i = 0; i < ROM_LATENCY; i++) r_pipe_id[i] <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rom_en <= w_found;
      if (w_found) begin
        r_ptr      <= rr_index(w_winner, 1);
        r_rom_addr <= w_addr[w_winner];
        r_issue_id <= w_winner;
      end
      // Stage 0 follows the registered issue; the last stage lines up with rom_data_in.
      r_pipe_vld[0] <= r_rom_en;
      r_pipe_id[0]  <= r_issue_id;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_id[i]  <= r_pipe_id[i-1];
      end
      r_rsp_valid <= r_pipe_vld[ROM_LATENCY-1];
      if (r_pipe_vld[ROM_LATENCY-1]) begin
        r_rsp_id   <= r_pipe_id[ROM_LATENCY-1];
        r_rsp_data <= rom_data_in;
      end
    end
  end

  assign rom_en_out    = r_rom_en;
  assign rom_addr_out  = r_rom_addr;
  assign rsp_valid_out = r_rsp_valid;
  assign rsp_id_out    = r_rsp_id;
  assign rsp_data_out  = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_sprite_rom_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sprite_rom_arbiter: directed checks of grant order, issue, latency and  |
// | reset for the default and a 3-requester/latency-1 build. Rev 1.0           |
// +----------------------------------------------------------------------------+
module tb_sprite_rom_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  req_valid;
  logic [63:0] req_addr;
  logic [3:0]  ready;
  logic [15:0] rom_addr;
  logic        rom_en;
  logic [7:0]  rom_data;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;

  logic [2:0]  req_valid_b;
  logic [47:0] req_addr_b;
  logic [2:0]  ready_b;
  logic [15:0] rom_addr_b;
  logic        rom_en_b;
  logic [7:0]  rom_data_b;
  logic        rsp_valid_b;
  logic [1:0]  rsp_id_b;
  logic [7:0]  rsp_data_b;

  int checks = 0;
  int errors = 0;

  sprite_rom_arbiter #(.NUM_REQ(4), .ADDR_W(16), .DATA_W(8), .ROM_LATENCY(2)) dut_a (
    .pixel_clk_in(clk), .rst_n_in(rst_n),
    .req_valid_in(req_valid), .req_addr_in(req_addr), .req_ready_out(ready),
    .rom_addr_out(rom_addr), .rom_en_out(rom_en), .rom_data_in(rom_data),
    .rsp_valid_out(rsp_valid), .rsp_id_out(rsp_id), .rsp_data_out(rsp_data)
  );

  sprite_rom_arbiter #(.NUM_REQ(3), .ADDR_W(16), .DATA_W(8), .ROM_LATENCY(1)) dut_b (
    .pixel_clk_in(clk), .rst_n_in(rst_n),
    .req_valid_in(req_valid_b), .req_addr_in(req_addr_b), .req_ready_out(ready_b),
    .rom_addr_out(rom_addr_b), .rom_en_out(rom_en_b), .rom_data_in(rom_data_b),
    .rsp_valid_out(rsp_valid_b), .rsp_id_out(rsp_id_b), .rsp_data_out(rsp_data_b)
  );

  // ROM contents: low byte ^ high byte ^ 0x83 (0x1234 -> 0xA5).
  function automatic logic [7:0] rom_word(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h83;
  endfunction

  logic [7:0] rom_a_d1, rom_a_d2, rom_b_d1;
  always @(posedge clk) begin
    rom_a_d1 <= rom_word(rom_addr);
    rom_a_d2 <= rom_a_d1;
    rom_b_d1 <= rom_word(rom_addr_b);
  end
  assign rom_data   = rom_a_d2;
  assign rom_data_b = rom_b_d1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid   = 4'h0;
    req_valid_b = 3'h0;
    rst_n       = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  logic [15:0] a4 [4] = '{16'h0100, 16'h0211, 16'h0322, 16'h0433};
  logic [7:0]  d4 [4] = '{8'h82, 8'h90, 8'hA2, 8'hB4};
  logic [3:0]  t3_vld [3] = '{4'b0110, 4'b0110, 4'b0101};
  logic [3:0]  t3_gnt [3] = '{4'b0010, 4'b0100, 4'b0001};
  logic [1:0]  t3_id  [3] = '{2'd1, 2'd2, 2'd0};
  logic [2:0]  tb_gnt [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [1:0]  tb_id  [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
  logic [7:0]  tb_dat [4] = '{8'h93, 8'hA2, 8'hB1, 8'h93};

  initial begin
    rst_n       = 1'b1;
    req_valid   = 4'h0;
    req_valid_b = 3'h0;
    req_addr    = '0;
    req_addr_b  = {16'h0230, 16'h0120, 16'h0010};
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_rom_en", 32'(rom_en), 0);
    check_eq("rst_rom_addr", 32'(rom_addr), 0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 0);
    check_eq("rst_rsp_id", 32'(rsp_id), 0);
    check_eq("rst_rsp_data", 32'(rsp_data), 0);
    check_eq("rst_ready", 32'(ready), 0);
    do_reset();

    // Single request from requester 2.
    req_addr[32 +: 16] = 16'h1234;
    step(); req_valid = 4'b0100; #1;
    check_eq("t1_ready", 32'(ready), 32'h4);
    step(); req_valid = 4'b0000; #1;
    check_eq("t1_rom_en", 32'(rom_en), 1);
    check_eq("t1_rom_addr", 32'(rom_addr), 32'h1234);
    check_eq("t1_ready_idle", 32'(ready), 0);
    step(); #1;
    check_eq("t1_rom_en_off", 32'(rom_en), 0);
    check_eq("t1_rom_addr_hold", 32'(rom_addr), 32'h1234);
    step(); #1;
    check_eq("t1_rsp_early", 32'(rsp_valid), 0);
    step(); #1;
    check_eq("t1_rsp_valid", 32'(rsp_valid), 1);
    check_eq("t1_rsp_id", 32'(rsp_id), 2);
    check_eq("t1_rsp_data", 32'(rsp_data), 32'hA5);
    step(); #1;
    check_eq("t1_rsp_done", 32'(rsp_valid), 0);
    check_eq("t1_rsp_id_hold", 32'(rsp_id), 2);
    check_eq("t1_rsp_data_hold", 32'(rsp_data), 32'hA5);

    // All four requesting for 8 cycles straight out of reset.
    do_reset();
    for (int i = 0; i < 4; i++) req_addr[i*16 +: 16] = a4[i];
    for (int k = 0; k < 13; k++) begin
      step();
      req_valid = (k < 8) ? 4'hF : 4'h0;
      #1;
      check_eq("t2_ready", 32'(ready), (k < 8) ? (32'h1 << (k % 4)) : 32'h0);
      if (k >= 1 && k <= 8) begin
        check_eq("t2_rom_en", 32'(rom_en), 1);
        check_eq("t2_rom_addr", 32'(rom_addr), 32'(a4[(k-1) % 4]));
      end
      if (k >= 4 && k <= 11) begin
        check_eq("t2_rsp_valid", 32'(rsp_valid), 1);
        check_eq("t2_rsp_id", 32'(rsp_id), 32'((k-4) % 4));
        check_eq("t2_rsp_data", 32'(rsp_data), 32'(d4[(k-4) % 4]));
      end else begin
        check_eq("t2_rsp_idle", 32'(rsp_valid), 0);
      end
    end

    // Pointer skip and wrap after the grant to 3.
    for (int k = 0; k < 8; k++) begin
      step();
      req_valid = (k < 3) ? t3_vld[k] : 4'h0;
      #1;
      if (k < 3) check_eq("t3_ready", 32'(ready), 32'(t3_gnt[k]));
      if (k >= 4 && k <= 6) begin
        check_eq("t3_rsp_valid", 32'(rsp_valid), 1);
        check_eq("t3_rsp_id", 32'(rsp_id), 32'(t3_id[k-4]));
      end
    end

    // Withdraw: requester 1 drops valid before its turn.
    step(); req_valid = 4'b1000; #1;
    check_eq("t4_ready_3", 32'(ready), 32'h8);
    step(); req_valid = 4'b0011; #1;
    check_eq("t4_ready_0", 32'(ready), 32'h1);
    step(); req_valid = 4'b0000; #1;
    check_eq("t4_ready_none", 32'(ready), 0);
    check_eq("t4_rom_addr0", 32'(rom_addr), 32'h0100);
    step(); #1;
    check_eq("t4_rom_en_off", 32'(rom_en), 0);
    check_eq("t4_rom_addr_hold", 32'(rom_addr), 32'h0100);
    step(); #1;
    check_eq("t4_rsp_id3", 32'(rsp_id), 3);
    step(); #1;
    check_eq("t4_rsp_id0", 32'(rsp_id), 0);
    step(); #1;
    check_eq("t4_no_rsp1", 32'(rsp_valid), 0);

    // Reset mid-flight: grants 1,2,3 then reset after the third issue.
    for (int k = 0; k < 4; k++) begin
      step();
      req_valid = (k < 3) ? 4'hF : 4'h0;
      #1;
      if (k < 3) check_eq("t5_ready", 32'(ready), 32'h2 << k);
    end
    step(); #1;
    check_eq("t5_rsp_first", 32'(rsp_valid), 1);
    check_eq("t5_rsp_first_id", 32'(rsp_id), 1);
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_rom_en", 32'(rom_en), 0);
    check_eq("t5_rst_rom_addr", 32'(rom_addr), 0);
    check_eq("t5_rst_rsp_valid", 32'(rsp_valid), 0);
    check_eq("t5_rst_rsp_id", 32'(rsp_id), 0);
    check_eq("t5_rst_rsp_data", 32'(rsp_data), 0);
    step(); rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(); #1;
      check_eq("t5_no_stale_rsp", 32'(rsp_valid), 0);
    end
    step(); req_valid = 4'hF; #1;
    check_eq("t5_ptr_zero", 32'(ready), 32'h1);
    step(); req_valid = 4'h0;
    for (int k = 0; k < 5; k++) step();

    // Three requesters, ROM latency 1.
    for (int k = 0; k < 8; k++) begin
      step();
      req_valid_b = (k < 4) ? 3'b111 : 3'b000;
      #1;
      check_eq("t6_ready", 32'(ready_b), (k < 4) ? 32'(tb_gnt[k]) : 32'h0);
      if (k >= 3 && k <= 6) begin
        check_eq("t6_rsp_valid", 32'(rsp_valid_b), 1);
        check_eq("t6_rsp_id", 32'(rsp_id_b), 32'(tb_id[k-3]));
        check_eq("t6_rsp_data", 32'(rsp_data_b), 32'(tb_dat[k-3]));
      end else begin
        check_eq("t6_rsp_idle", 32'(rsp_valid_b), 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
